// File: rtl/fetch_if.sv
// Fetch-unit bus: instruction-memory port, fetch control and the decode handshake.
interface fetch_if #(
    parameter int unsigned WORD_SIZE = 32
);
    logic [WORD_SIZE-1:0] imem_addr;
    logic [WORD_SIZE-1:0] imem_data;
    logic                 halt;
    logic                 redirect_valid;
    logic [WORD_SIZE-1:0] redirect_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_inst;
    logic [WORD_SIZE-1:0] out_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        input  halt,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output halt,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register feeding a 2-entry {pc, inst} FIFO toward decode.
module fetch_unit #(
    parameter int unsigned          WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
    parameter logic [WORD_SIZE-1:0] PC_STEP   = WORD_SIZE'(1)
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  fif
);
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [1:0]           count_q, count_d;
    logic [WORD_SIZE-1:0] pc0_q, pc0_d, inst0_q, inst0_d;
    logic [WORD_SIZE-1:0] pc1_q, pc1_d, inst1_q, inst1_d;
    logic                 pop, push;

    always_comb begin
        pop  = (count_q != 2'd0) && fif.out_ready && !fif.redirect_valid;
        push = !fif.halt && !fif.redirect_valid && ((count_q != 2'd2) || pop);

        pc_d    = pc_q;
        count_d = count_q;
        pc0_d   = pc0_q;
        inst0_d = inst0_q;
        pc1_d   = pc1_q;
        inst1_d = inst1_q;

        if (fif.redirect_valid) begin
            pc_d    = fif.redirect_pc;
            count_d = 2'd0;
            pc0_d   = '0;
            inst0_d = '0;
            pc1_d   = '0;
            inst1_d = '0;
        end else begin
            if (push) pc_d = pc_q + PC_STEP;
            // Entry 0 is always the head; a pop shifts entry 1 down and clears it.
            if (pop) begin
                pc0_d   = pc1_q;
                inst0_d = inst1_q;
                pc1_d   = '0;
                inst1_d = '0;
            end
            if (push) begin
                if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
                    pc0_d   = pc_q;
                    inst0_d = fif.imem_data;
                end else begin
                    pc1_d   = pc_q;
                    inst1_d = fif.imem_data;
                end
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            count_q <= 2'd0;
            pc0_q   <= '0;
            inst0_q <= '0;
            pc1_q   <= '0;
            inst1_q <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            pc0_q   <= pc0_d;
            inst0_q <= inst0_d;
            pc1_q   <= pc1_d;
            inst1_q <= inst1_d;
        end
    end

    assign fif.imem_addr = pc_q;
    assign fif.out_valid = (count_q != 2'd0);
    assign fif.out_pc    = fif.out_valid ? pc0_q   : '0;
    assign fif.out_inst  = fif.out_valid ? inst0_q : '0;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter WORD_SIZE, default 32, width of instruction words, PCs and instruction-memory addresses.
REQ-002 Parameter RESET_PC, default 0, PC loaded on reset.
REQ-003 Parameter PC_STEP, default 1, PC increment per fetch; the memory is word-addressed.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 imem_addr  output  WORD_SIZE  address driven to inst_memory ptr; equals the current PC register.
REQ-007 imem_data  input  WORD_SIZE  inst_memory out; combinational, valid in the same cycle as imem_addr.
REQ-008 halt  input  1  when high, no new fetch is performed.
REQ-009 redirect_valid  input  1  branch/jump redirect request.
REQ-010 redirect_pc  input  WORD_SIZE  redirect target PC.
REQ-011 out_valid  output  1  head instruction available to decode.
REQ-012 out_ready  input  1  decode accepts the head this cycle.
REQ-013 out_inst  output  WORD_SIZE  head instruction word.
REQ-014 out_pc  output  WORD_SIZE  PC of the head instruction.

Function
REQ-015 The block SHALL hold a 2-entry FIFO of {pc, inst} pairs with a count of 0..2.
REQ-016 A pop SHALL occur when out_valid=1 and out_ready=1 at the clock edge.
REQ-017 A fetch SHALL occur when halt=0, redirect_valid=0, and either count<2 or a pop occurs in the same cycle.
REQ-018 A fetch SHALL push {PC, imem_data} into the FIFO tail and update PC to PC+PC_STEP, modulo 2^WORD_SIZE.
REQ-019 out_valid SHALL be 1 exactly when count!=0; out_inst and out_pc SHALL be the head entry, and 0 when count=0.
REQ-020 Latency: an instruction fetched at edge N SHALL appear on out_* in the cycle after edge N when the FIFO was empty.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged and preserve order; this includes the full case (count=2).
REQ-022 At count=2 with no pop, no fetch SHALL occur, and PC and imem_addr SHALL hold.
REQ-023 redirect_valid=1 SHALL take priority over push and pop.
REQ-024 On redirect, the FIFO SHALL be flushed (count=0), PC SHALL be set to redirect_pc, and no push or pop SHALL be counted.
REQ-025 After a redirect, out_valid SHALL be 0 in the next cycle; the first instruction at redirect_pc SHALL be valid one cycle later if halt=0.
REQ-026 halt=1 SHALL stop fetches only; pops SHALL continue, and the FIFO SHALL drain.
REQ-027 A redirect during halt SHALL still flush the FIFO and load the PC.
REQ-028 The decode handshake SHALL follow these rules:
- out_inst and out_pc SHALL be stable while out_valid=1 and out_ready=0.
- out_valid SHALL never drop without a pop or a redirect.
REQ-029 No instruction SHALL be dropped or duplicated under any out_ready pattern, absent a redirect.

Reset
REQ-030 rst_n=0 SHALL immediately, without a clock, set PC=RESET_PC, count=0, and FIFO entries=0.
REQ-031 While rst_n=0, outputs SHALL be imem_addr=RESET_PC, out_valid=0, out_inst=0, and out_pc=0.
REQ-032 Reset asserted mid-operation SHALL discard all queued instructions.
REQ-033 Fetching SHALL resume from RESET_PC at the first rising edge after rst_n deasserts.

Verification
REQ-034 Reset then out_ready=1, memory word[n]=n+0x100: out_valid=1 from cycle 1, with out_pc 0,1,2,3 and out_inst 0x100,0x101,0x102,0x103 on consecutive cycles.
REQ-035 out_ready=0 for 5 cycles after reset, then 1: count saturates at 2, imem_addr holds 2, and the output sequence is pc 0,1,2,... with no gaps.
REQ-036 FIFO full, redirect_valid=1 with redirect_pc=0x40 and out_ready=1: next cycle out_valid=0, then out_pc=0x40 and out_inst=0x140.
REQ-037 redirect_pc=0xFFFFFFFF: out_pc sequence is 0xFFFFFFFF then 0x00000000 (wrap).
REQ-038 halt=1 with count=2 and out_ready=1: two pops, then out_valid=0 and imem_addr constant; halt=0 resumes at the held PC.
REQ-039 rst_n pulsed low mid-stream with count=2: out_valid=0 immediately, and after release out_pc restarts at 0.
